// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for the single-cycle core: word RAM plus LED / CYCLE / TX-FIFO MMIO window.
// Latency: loads are combinational from dmem_addr; stores and FIFO pushes take effect at the next clk edge.
// Backpressure: tx_valid/tx_ready on the TX byte stream; a push into a full FIFO with no pop is dropped and sets sticky ovf.
module dmem_mmio_responder #(
   parameter int          MEM_WORDS  = 64,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] MMIO_BASE  = 32'h0000_FF00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] dmem_addr,
   input  logic        dmem_write,
   input  logic [31:0] dmem_write_data,
   output logic [31:0] dmem_read_data,
   output logic [7:0]  leds,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int         AW     = $clog2(MEM_WORDS);
   localparam int         PW     = $clog2(FIFO_DEPTH);
   // count runs 0..FIFO_DEPTH, so five bits covers the largest legal depth of 16
   localparam logic [4:0] DEPTH5 = 5'(FIFO_DEPTH);

   // MMIO register offsets (word index inside the 16-byte window)
   localparam logic [1:0] OFF_LED    = 2'd0;
   localparam logic [1:0] OFF_CYCLE  = 2'd1;
   localparam logic [1:0] OFF_TXDATA = 2'd2;
   localparam logic [1:0] OFF_STATUS = 2'd3;

   // storage and architectural state
   logic [31:0]   r_mem  [MEM_WORDS];
   logic [7:0]    r_fifo [FIFO_DEPTH];
   logic [7:0]    r_leds;
   logic [31:0]   r_cycle;
   logic [PW-1:0] r_rptr;
   logic [PW-1:0] r_wptr;
   logic [4:0]    r_count;
   logic          r_ovf;

   // decode and handshake terms
   logic          w_is_mmio;
   logic [1:0]    w_off;
   logic [AW-1:0] w_ram_idx;
   logic          w_ram_we;
   logic          w_led_we;
   logic          w_cyc_we;
   logic          w_tx_we;
   logic          w_stat_we;
   logic          w_full;
   logic          w_empty;
   logic          w_pop;
   logic          w_push;
   logic          w_ovf_set;
   logic          w_ovf_clr;
   logic [31:0]   w_status;
   logic          w_addr_lsb_unused;

   // byte lanes are not supported, so the two low address bits never matter
   assign w_addr_lsb_unused = ^dmem_addr[1:0];

   // everything whose upper 28 bits match the window base is MMIO; all other addresses alias into RAM
   assign w_is_mmio = (dmem_addr[31:4] == MMIO_BASE[31:4]);
   assign w_off     = dmem_addr[3:2];
   assign w_ram_idx = dmem_addr[AW+1:2];

   // per-target write strobes; RAM and MMIO are mutually exclusive by the decode above
   assign w_ram_we  = dmem_write && !w_is_mmio;
   assign w_led_we  = dmem_write &&  w_is_mmio && (w_off == OFF_LED);
   assign w_cyc_we  = dmem_write &&  w_is_mmio && (w_off == OFF_CYCLE);
   assign w_tx_we   = dmem_write &&  w_is_mmio && (w_off == OFF_TXDATA);
   assign w_stat_we = dmem_write &&  w_is_mmio && (w_off == OFF_STATUS);

   // FIFO occupancy flags and the consumer handshake
   assign w_full  = (r_count == DEPTH5);
   assign w_empty = (r_count == 5'd0);
   assign w_pop   = !w_empty && tx_ready;

   // a pop in the same cycle frees the slot, so a push into a full FIFO is still accepted then
   assign w_push    = w_tx_we && (!w_full || w_pop);
   assign w_ovf_set = w_tx_we && w_full && !w_pop;
   assign w_ovf_clr = w_stat_we && dmem_write_data[8];

   assign w_status = {23'b0, r_ovf, r_count[3:0], 2'b00, w_empty, w_full};

   // outputs straight from registers; tx_data holds while stalled because rptr only moves on a pop
   assign leds     = r_leds;
   assign tx_valid = !w_empty;
   assign tx_data  = r_fifo[r_rptr];

   // combinational load path: the core expects data in the same cycle it presents the address
   always_comb begin
      dmem_read_data = r_mem[w_ram_idx];
      if (w_is_mmio) begin
         case (w_off)
            OFF_LED:    dmem_read_data = {24'b0, r_leds};
            OFF_CYCLE:  dmem_read_data = r_cycle;
            OFF_TXDATA: dmem_read_data = 32'b0;
            default:    dmem_read_data = w_status;
         endcase
      end
   end

   // word RAM: synchronous write, contents deliberately left unreset
   always_ff @(posedge clk) begin
      if (w_ram_we) begin
         r_mem[w_ram_idx] <= dmem_write_data;
      end
   end

   // FIFO byte storage: written only on an accepted push, no reset needed since tx_valid masks it
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wptr] <= dmem_write_data[7:0];
      end
   end

   // LED register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_leds <= 8'h00;
      end else if (w_led_we) begin
         r_leds <= dmem_write_data[7:0];
      end
   end

   // free-running cycle counter; a store loads it instead of incrementing on that edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cycle <= 32'h0;
      end else if (w_cyc_we) begin
         r_cycle <= dmem_write_data;
      end else begin
         r_cycle <= r_cycle + 32'd1;
      end
   end

   // FIFO pointers and occupancy; pointers wrap for free because the depth is a power of two
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_count <= 5'd0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 5'd1;
            2'b01:   r_count <= r_count - 5'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // sticky overflow flag; a dropped byte on the same edge as a clear keeps the flag set
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ovf <= 1'b0;
      end else if (w_ovf_set) begin
         r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Responder (target) end of the single-cycle core's data-memory port.
- Services the core's word loads and stores: word-addressed data RAM plus a small memory-mapped I/O window.
- MMIO window holds an LED register, a free-running cycle counter, and a byte-wide transmit FIFO drained by an external valid/ready consumer (console/UART shim).
- Sits at top level between the core's dmem port and the board I/O.

Parameters:
- MEM_WORDS, 64: RAM depth in 32-bit words. Power of two, ≥4.
- FIFO_DEPTH, 4: TX FIFO depth in bytes. Power of two, 2..16.
- MMIO_BASE, 32'h0000_FF00: base of the 16-byte MMIO window. Bits [3:0] are zero.

Ports:
- clk, input, 1: system clock; all state updates on rising edge.
- reset, input, 1: asynchronous, active-low reset.
- dmem_addr, input, 32: byte address from the core (its ALU result).
- dmem_write, input, 1: store strobe; effective at the next rising edge.
- dmem_write_data, input, 32: store data.
- dmem_read_data, output, 32: load data, combinational from dmem_addr.
- leds, output, 8: LED register value.
- tx_data, output, 8: FIFO head byte.
- tx_valid, output, 1: FIFO non-empty.
- tx_ready, input, 1: consumer accepts tx_data this cycle.

Behaviour:
- Address decode:
  - MMIO when dmem_addr[31:4] == MMIO_BASE[31:4]; otherwise RAM.
  - dmem_addr[1:0] ignored; accesses are word-only.
- RAM:
  - Index = dmem_addr[log2(MEM_WORDS)+1:2]; upper bits ignored, so the RAM aliases across non-MMIO space.
  - Read is combinational (zero latency, as the single-cycle core requires).
  - Write is synchronous on the edge where dmem_write=1.
  - Contents are not reset.
- MMIO registers (offset = dmem_addr[3:2]):
  - 0 LED: RW. Write stores dmem_write_data[7:0]. Read returns {24'b0, leds}.
  - 1 CYCLE: RW, 32-bit.
    - Increments by 1 every edge, wrapping 0xFFFF_FFFF→0.
    - A write loads dmem_write_data instead of incrementing (load wins).
    - Read returns the current value.
  - 2 TXDATA: WO.
    - Write pushes dmem_write_data[7:0] into the FIFO.
    - Read returns 0.
  - 3 STATUS: read returns {23'b0, ovf, count[3:0], 2'b0, empty, full}, i.e. bit0=full, bit1=empty, bits[7:4]=count, bit8=ovf.
    - Write with dmem_write_data[8]=1 clears ovf; other bits ignored.
- FIFO:
  - Circular buffer with read pointer, write pointer and count (0..FIFO_DEPTH). Pointers wrap modulo FIFO_DEPTH.
  - tx_valid = (count != 0); tx_data = mem[rptr], valid whenever tx_valid.
  - Pop on tx_valid && tx_ready. Push on a TXDATA write.
  - Push and pop in the same cycle: both occur and count is unchanged. This applies even when full, with no overflow.
  - Push while full with no pop: byte dropped, ovf set to 1 (sticky). ovf set and STATUS clear in the same edge: set wins.
  - tx_ready while empty: no effect.
  - tx_data/tx_valid must hold stable while tx_valid && !tx_ready.
- Reset (reset=0, asynchronous, at any time including mid-transfer):
  - leds=0, CYCLE=0, count=0, pointers=0, ovf=0.
  - tx_valid drops to 0 immediately. dmem_read_data follows the decode of the reset state.
  - After deassertion, CYCLE reads 0 before the first edge and 1 after it.
- Writes to RAM and MMIO are exclusive by decode; a write never affects both.

Test Plan:
- Reset, then store 0xDEADBEEF to 0x10 and load 0x10 -> read 0xDEADBEEF. Load (0x10 + 4*MEM_WORDS) -> same value (alias).
- Store 0x1A5 to LED -> leds=0xA5, LED read = 0x0000_00A5. Store 0xFFFF_FFFE to CYCLE -> reads 0xFFFF_FFFE, then 0xFFFF_FFFF, then 0 on successive cycles.
- tx_ready=0; write bytes 0x41..0x44 to TXDATA -> STATUS=0x041 (count 4, full). Fifth write 0x45 -> STATUS=0x141. Drain with tx_ready=1 -> tx_data 0x41,0x42,0x43,0x44 on consecutive cycles, then tx_valid=0 and STATUS=0x102.
- FIFO full, simultaneous TXDATA write 0x55 and pop -> count stays 4, ovf stays 0, 0x55 emerges last.
- Write STATUS with bit8=1 -> ovf=0. In the same cycle as an overflowing push -> ovf=1.
- Assert reset mid-drain with 3 bytes queued -> tx_valid=0 asynchronously, leds=0. After release STATUS=0x002 and CYCLE=0.
